// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: operand stage in front of the 8-bit ALU.
// It holds a small register file and accepts one instruction at a time over
// a valid/ready handshake. For each instruction it reads two sources,
// prepares operand 2 (two's complement plus carry for SUB), issues to the
// ALU, waits a settle window, then writes the ALU result back to dst.
// Optional immediate operand: define OPF_IMMEDIATE_EN to add OPF_imm_sel /
// OPF_imm. When imm_sel is set, operand B comes from OPF_imm, not rf[src2].
module alu_operand_fetch #(
  parameter int NUM_REGS      = 4,
  parameter int ADDR_W        = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              OPF_clk,
  input  logic              OPF_rst,
  input  logic              OPF_instr_valid,
  output logic              OPF_instr_ready,
  input  logic [2:0]        OPF_opcode,
  input  logic [ADDR_W-1:0] OPF_src1,
  input  logic [ADDR_W-1:0] OPF_src2,
  input  logic [ADDR_W-1:0] OPF_dst,
`ifdef OPF_IMMEDIATE_EN
  input  logic              OPF_imm_sel,
  input  logic [7:0]        OPF_imm,
`endif
  input  logic              OPF_wr_en,
  input  logic [ADDR_W-1:0] OPF_wr_addr,
  input  logic [7:0]        OPF_wr_data,
  input  logic [7:0]        OPF_alu_result,
  output logic [7:0]        OPF_alu_input1,
  output logic [7:0]        OPF_alu_input2,
  output logic [2:0]        OPF_alu_operation,
  output logic              OPF_alu_read_enable,
  output logic              OPF_alu_complement_carry,
  output logic              OPF_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_PREP   = 3'd2,
    S_ISSUE  = 3'd3,
    S_SETTLE = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [2:0] OP_SUB      = 3'b111;
  // The settle counter counts down to zero, so the dwell is SETTLE_CYCLES.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t              state_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   src1_q;
  logic [ADDR_W-1:0]   src2_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [7:0]          a_q;
  logic [7:0]          b_q;
  logic [3:0]          cnt_q;
  logic [7:0]          rf_q [NUM_REGS];

`ifdef OPF_IMMEDIATE_EN
  logic                imm_sel_q;
  logic [7:0]          imm_q;
`endif

  // Registered ALU-side outputs.
  logic [7:0]          in1_q;
  logic [7:0]          in2_q;
  logic [2:0]          aop_q;
  logic                re_q;
  logic                cc_q;
  logic                done_q;

  // Combinational next values.
  logic [7:0]          b_fetch_d;
  logic [7:0]          b2_d;
  logic                cc_d;
  logic [8:0]          neg_b;
  logic                handshake;
  logic                wb_we;

  // Ready is gated by reset directly, so it reads 0 during reset even in IDLE.
  assign OPF_instr_ready = (state_q == S_IDLE) && !OPF_rst;
  assign handshake       = OPF_instr_valid && OPF_instr_ready;
  assign wb_we           = (state_q == S_WB);

  assign OPF_alu_input1           = in1_q;
  assign OPF_alu_input2           = in2_q;
  assign OPF_alu_operation        = aop_q;
  assign OPF_alu_read_enable      = re_q;
  assign OPF_alu_complement_carry = cc_q;
  assign OPF_done                 = done_q;

  // Select the value captured as operand B in FETCH.
  always_comb begin
    b_fetch_d = rf_q[src2_q];
`ifdef OPF_IMMEDIATE_EN
    if (imm_sel_q) b_fetch_d = imm_q;
`endif
  end

  // Prepare operand 2: negate for SUB. The carry out of ~B+1 is set only
  // when B is zero.
  always_comb begin
    neg_b = {1'b0, ~b_q} + 9'd1;
    b2_d  = b_q;
    cc_d  = 1'b0;
    if (op_q == OP_SUB) begin
      b2_d = neg_b[7:0];
      cc_d = neg_b[8];
    end
  end

  // Instruction sequencer: handshake, fetch, prepare, issue, settle and
  // writeback. ALU outputs are registered here.
  always_ff @(posedge OPF_clk) begin
    if (OPF_rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      dst_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      aop_q     <= '0;
      re_q      <= 1'b0;
      cc_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef OPF_IMMEDIATE_EN
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
`endif
    end else begin
      // The read-enable and done pulses last one cycle unless set below.
      re_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            op_q      <= OPF_opcode;
            src1_q    <= OPF_src1;
            src2_q    <= OPF_src2;
            dst_q     <= OPF_dst;
`ifdef OPF_IMMEDIATE_EN
            imm_sel_q <= OPF_imm_sel;
            imm_q     <= OPF_imm;
`endif
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Register reads see the contents before any same-edge write.
          a_q     <= rf_q[src1_q];
          b_q     <= b_fetch_d;
          state_q <= S_PREP;
        end
        S_PREP: begin
          in1_q   <= a_q;
          in2_q   <= b2_d;
          aop_q   <= op_q;
          cc_q    <= cc_d;
          re_q    <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt_q   <= SETTLE_LOAD;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) begin
            done_q  <= 1'b1;
            state_q <= S_WB;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Register file. Writeback takes priority over an external write to the
  // same address. Writes to different addresses both land.
  always_ff @(posedge OPF_clk) begin
    if (OPF_rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      if (OPF_wr_en && !(wb_we && (OPF_wr_addr == dst_q)))
        rf_q[OPF_wr_addr] <= OPF_wr_data;
      if (wb_we)
        rf_q[dst_q] <= OPF_alu_result;
    end
  end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch.
// The driver issues instructions and pushes expected ALU-issue records.
// The monitor pops and compares them on read_enable and done pulses.
// Register contents are modelled by the bench and observed through ISSUE.
module tb_alu_operand_fetch;
  localparam int NR = 4;
  localparam int AW = 2;
  localparam int SC = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [2:0]    opcode;
  logic [AW-1:0] src1, src2, dst, wr_addr;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic [7:0]    alu_result;
  logic [7:0]    in1, in2;
  logic [2:0]    aop;
  logic          re, cc, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_hs  = -100;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b2;
    logic [2:0] op;
    logic       cc;
    int         hs;
  } exp_t;

  exp_t       issue_q[$];
  exp_t       wb_q[$];
  logic [7:0] mrf [NR];

  alu_operand_fetch #(.NUM_REGS(NR), .ADDR_W(AW), .SETTLE_CYCLES(SC)) dut (
    .OPF_clk                 (clk),
    .OPF_rst                 (rst),
    .OPF_instr_valid         (valid),
    .OPF_instr_ready         (ready),
    .OPF_opcode              (opcode),
    .OPF_src1                (src1),
    .OPF_src2                (src2),
    .OPF_dst                 (dst),
`ifdef OPF_IMMEDIATE_EN
    .OPF_imm_sel             (1'b0),
    .OPF_imm                 (8'h00),
`endif
    .OPF_wr_en               (wr_en),
    .OPF_wr_addr             (wr_addr),
    .OPF_wr_data             (wr_data),
    .OPF_alu_result          (alu_result),
    .OPF_alu_input1          (in1),
    .OPF_alu_input2          (in2),
    .OPF_alu_operation       (aop),
    .OPF_alu_read_enable     (re),
    .OPF_alu_complement_carry(cc),
    .OPF_done                (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ALU stand-in. For sub, operand 2 arrives pre-negated, so
  // the ALU simply adds.
  function automatic logic [7:0] alu_fn(logic [7:0] x, logic [7:0] y, logic [2:0] op);
    case (op)
      3'd1:    return x & y;
      3'd2:    return x | y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return x ^ y;
      3'd6:    return ~(x ^ y);
      default: return x + y;
    endcase
  endfunction

  assign alu_result = alu_fn(in1, in2, aop);

  // Architectural result of an instruction on register values a, b.
  function automatic logic [7:0] ref_res(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    int r;
    case (op)
      3'd0:    r = int'(a) + int'(b);
      3'd7:    r = int'(a) - int'(b);
      3'd1:    r = int'(a & b);
      3'd2:    r = int'(a | b);
      3'd3:    r = int'(~(a & b));
      3'd4:    r = int'(~(a | b));
      3'd5:    r = int'(a ^ b);
      default: r = int'(~(a ^ b));
    endcase
    return 8'(r);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare against the scoreboard whenever the DUT presents output.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (re) begin
        if (issue_q.size() == 0) begin
          chk("spurious_read_enable", 32'(re), 32'd0);
        end else begin
          e = issue_q.pop_front();
          chk("issue_input1", 32'(in1), 32'(e.a));
          chk("issue_input2", 32'(in2), 32'(e.b2));
          chk("issue_operation", 32'(aop), 32'(e.op));
          chk("issue_carry", 32'(cc), 32'(e.cc));
          chk("read_enable_latency", 32'(cyc - e.hs), 32'd2);
          wb_q.push_back(e);
        end
      end
      if (done) begin
        if (wb_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          e = wb_q.pop_front();
          chk("done_latency", 32'(cyc - e.hs), 32'(3 + SC));
          chk("hold_input1", 32'(in1), 32'(e.a));
          chk("hold_input2", 32'(in2), 32'(e.b2));
          chk("hold_carry", 32'(cc), 32'(e.cc));
          chk("done_re_low", 32'(re), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_wr(int a, logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    mrf[a]  = d;
  endtask

  // Present an instruction, wait (bounded) for acceptance, and push the
  // expected issue record. hold keeps valid high afterwards; gap_chk checks
  // back-to-back spacing; commit updates the model register file.
  task automatic do_instr(int op, int s1, int s2, int d, bit hold, bit gap_chk, bit commit);
    logic [7:0] a, b;
    int n;
    exp_t e;
    opcode = 3'(op);
    src1   = AW'(s1);
    src2   = AW'(s2);
    dst    = AW'(d);
    valid  = 1'b1;
    n = 0;
    while (ready !== 1'b1) begin
      tick();
      n++;
      if (n > 40) begin
        chk("accept_timeout", 32'(ready), 32'd1);
        valid = 1'b0;
        return;
      end
    end
    tick();
    if (gap_chk) chk("back_to_back_gap", 32'(cyc - last_hs), 32'(5 + SC));
    last_hs = cyc;
    a    = mrf[s1];
    b    = mrf[s2];
    e.a  = a;
    e.b2 = (op == 7) ? 8'(256 - int'(b)) : b;
    e.op = 3'(op);
    e.cc = (op == 7) && (b == 8'h00);
    e.hs = cyc;
    issue_q.push_back(e);
    if (commit) mrf[d] = ref_res(a, b, 3'(op));
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ready === 1'b1 && issue_q.size() == 0 && wb_q.size() == 0)) begin
      tick();
      n++;
      if (n > 60) begin
        chk("drain_timeout", 32'(issue_q.size() + wb_q.size()), 32'd0);
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_hold, hold;
    int n;
    rst = 1'b1; valid = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    opcode = '0; src1 = '0; src2 = '0; dst = '0;
    for (int i = 0; i < NR; i++) mrf[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_input1", 32'(in1), 32'd0);
    chk("reset_input2", 32'(in2), 32'd0);
    chk("reset_operation", 32'(aop), 32'd0);
    chk("reset_read_enable", 32'(re), 32'd0);
    chk("reset_carry", 32'(cc), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ready), 32'd1);
    @(posedge clk); #1;

    // or r0,r0 after reset reads zeros.
    do_instr(2, 0, 0, 0, 0, 0, 1);
    wait_idle();

    // add r3 = r1 + r2.
    ext_wr(1, 8'h3C);
    ext_wr(2, 8'h05);
    do_instr(0, 1, 2, 3, 0, 0, 1);
    wait_idle();

    // Sub: non-zero operand, then zero operand (carry set).
    ext_wr(1, 8'h10);
    ext_wr(2, 8'h01);
    do_instr(7, 1, 2, 0, 0, 0, 1);
    wait_idle();
    ext_wr(2, 8'h00);
    do_instr(7, 1, 2, 0, 0, 0, 1);
    wait_idle();

    // Valid held across two instructions; the second depends on the first.
    ext_wr(1, 8'h3C);
    ext_wr(2, 8'h05);
    do_instr(0, 1, 2, 3, 1, 0, 1);
    do_instr(5, 3, 1, 2, 0, 1, 1);
    wait_idle();

    // External write collides with writeback to r3; then to r0 at writeback.
    ext_wr(2, 8'h05);
    for (int k = 0; k < 2; k++) begin
      do_instr(0, 1, 2, 3, 0, 0, 1);
      n = 0;
      while (done !== 1'b1 && n < 20) begin tick(); n++; end
      chk("collision_done_seen", 32'(done), 32'd1);
      wr_en   = 1'b1;
      wr_addr = (k == 0) ? AW'(3) : AW'(0);
      wr_data = 8'hAA;
      tick();
      wr_en = 1'b0;
      if (k == 1) mrf[0] = 8'hAA;
      wait_idle();
    end
    do_instr(2, 3, 0, 1, 0, 0, 1);
    wait_idle();

    // Reset while in SETTLE aborts the instruction.
    do_instr(0, 1, 2, 3, 0, 0, 0);
    repeat (3) tick();
    rst = 1'b1;
    issue_q.delete();
    wb_q.delete();
    tick();
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_input1", 32'(in1), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) mrf[i] = 8'h00;
    @(negedge clk);
    chk("abort_ready_released", 32'(ready), 32'd1);
    @(posedge clk); #1;
    do_instr(2, 3, 3, 0, 0, 0, 1);
    wait_idle();

    // Randomized instruction stream with occasional back-to-back issue.
    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!prev_hold) begin
        wait_idle();
        repeat ($urandom_range(0, 2)) ext_wr(int'($urandom_range(0, NR - 1)), 8'($urandom));
      end
      hold = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      do_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, NR - 1)),
               int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
               hold, prev_hold, 1);
      prev_hold = hold;
    end
    wait_idle();
    chk("final_queue_empty", 32'(issue_q.size() + wb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
